// File: rtl/w5300_bus_master.sv
// W5300 host-bus access engine: one command per handshake,
// timed CS/RD/WR strobes, streamed write data in, read data out.
module w5300_bus_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int SETUP  = 5,
  parameter int ACTIVE = 5,
  parameter int HOLD   = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdWrite,
  input  logic [ADDR_W-1:0] CmdAddr,
  input  logic [LEN_W-1:0]  CmdLen,
  input  logic              CmdInc,
  input  logic [DATA_W-1:0] WrData,
  input  logic              WrValid,
  output logic              WrReady,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] LanAddr,
  output logic [DATA_W-1:0] LanDataOut,
  output logic              LanDataOe,
  input  logic [DATA_W-1:0] LanDataIn,
  output logic              LanCs,
  output logic              LanRd,
  output logic              LanWr
);

  localparam int MSA  = (SETUP > ACTIVE) ? SETUP : ACTIVE;
  localparam int MAXP = (MSA > HOLD) ? MSA : HOLD;
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] SL = CW'(SETUP - 1);
  localparam logic [CW-1:0] AL = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] HL = CW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACTIVE,
    S_HOLD,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                write_q, write_d;
  logic                inc_q, inc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdv_q, rdv_d;
  logic                wr_ready;

  // State and datapath registers; reset parks the bus idle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      write_q <= 1'b0;
      inc_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      write_q <= write_d;
      inc_q   <= inc_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
    end
  end

  // Next-state: phase timing, word counting, data capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    write_d  = write_q;
    inc_d    = inc_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;
    rdv_d    = 1'b0;
    wr_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          write_d = CmdWrite;
          inc_d   = CmdInc;
          addr_d  = CmdAddr;
          rem_d   = CmdLen;
          cnt_d   = '0;
          state_d = (CmdLen == '0) ? S_FIN : S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q != SL) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!write_q) begin
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end else if (WrValid) begin
          dout_d   = WrData;
          wr_ready = 1'b1;
          cnt_d    = '0;
          state_d  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (cnt_q != AL) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_HOLD;
          if (!write_q) begin
            rdata_d = LanDataIn;
            rdv_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q != HL) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_SETUP;
            if (inc_q) addr_d = addr_q + ADDR_W'(2);
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign CmdReady   = (state_q == S_IDLE) && !Rst;
  assign WrReady    = wr_ready;
  assign RdData     = rdata_q;
  assign RdValid    = rdv_q;
  assign Busy       = (state_q != S_IDLE);
  assign Done       = (state_q == S_FIN);
  assign LanAddr    = addr_q;
  assign LanDataOut = dout_q;
  assign LanDataOe  = (state_q != S_IDLE) && write_q;
  assign LanCs      = !(state_q == S_ACTIVE);
  assign LanWr      = !((state_q == S_ACTIVE) && write_q);
  assign LanRd      = !((state_q == S_ACTIVE) && !write_q);

endmodule

// File: tb/tb_w5300_bus_master.sv
// Bench for w5300_bus_master: cycle schedule model built from
// command-level rules, compared against the DUT every cycle.
module tb_w5300_bus_master;

  localparam int SETUP  = 5;
  localparam int ACTIVE = 5;
  localparam int HOLD   = 5;

  logic        Clk = 0;
  logic        Rst;
  logic        CmdValid, CmdReady, CmdWrite, CmdInc;
  logic [9:0]  CmdAddr;
  logic [7:0]  CmdLen;
  logic [15:0] WrData;
  logic        WrValid, WrReady;
  logic [15:0] RdData;
  logic        RdValid, Busy, Done;
  logic [9:0]  LanAddr;
  logic [15:0] LanDataOut, LanDataIn;
  logic        LanDataOe, LanCs, LanRd, LanWr;

  w5300_bus_master dut (
    .Clk(Clk), .Rst(Rst),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdWrite(CmdWrite), .CmdAddr(CmdAddr),
    .CmdLen(CmdLen), .CmdInc(CmdInc),
    .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
    .RdData(RdData), .RdValid(RdValid),
    .Busy(Busy), .Done(Done),
    .LanAddr(LanAddr), .LanDataOut(LanDataOut),
    .LanDataOe(LanDataOe), .LanDataIn(LanDataIn),
    .LanCs(LanCs), .LanRd(LanRd), .LanWr(LanWr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit rst; bit chk; int rel;
    bit cv; bit cw; bit ci;
    logic [9:0] ca; logic [7:0] cl;
    bit wv; logic [15:0] wd; logic [15:0] li;
    bit cr; bit busy; bit wrr; bit rdv; bit done;
    bit oe; bit cs; bit rd; bit wr;
    logic [9:0] addr; logic [15:0] dout; logic [15:0] rdata;
  } rec_t;

  rec_t sched[$];
  rec_t cur;

  int checks = 0;
  int fails  = 0;

  logic [9:0]  m_addr;
  logic [15:0] m_dout, m_rdata;
  int          stall_arr[256];
  logic [15:0] wd_arr[256];
  logic [15:0] rd_arr[256];

  int o_cs, o_cs_n, o_rd, o_rd_n, o_wr_n, o_oe_n;
  int o_wrr_n, o_done, o_done_n;
  bit prev_cs_low;
  logic [9:0]  o_addr[$];
  logic [15:0] o_dout[$];
  int          o_rdv_rel[$];
  logic [15:0] o_rdv_dat[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the expected record of this cycle
  always @(negedge Clk) begin
    if (cur.chk) begin
      chk("CmdReady", CmdReady, cur.cr);
      chk("Busy", Busy, cur.busy);
      chk("Done", Done, cur.done);
      chk("WrReady", WrReady, cur.wrr);
      chk("RdValid", RdValid, cur.rdv);
      chk("LanDataOe", LanDataOe, cur.oe);
      chk("LanCs", LanCs, cur.cs);
      chk("LanRd", LanRd, cur.rd);
      chk("LanWr", LanWr, cur.wr);
      chk("LanAddr", LanAddr, cur.addr);
      chk("LanDataOut", LanDataOut, cur.dout);
      chk("RdData", RdData, cur.rdata);
      if (!LanCs) begin
        if (o_cs < 0) o_cs = cur.rel;
        o_cs_n++;
        if (!prev_cs_low) begin
          o_addr.push_back(LanAddr);
          o_dout.push_back(LanDataOut);
        end
      end
      prev_cs_low = !LanCs;
      if (!LanRd) begin
        if (o_rd < 0) o_rd = cur.rel;
        o_rd_n++;
      end
      if (!LanWr) o_wr_n++;
      if (LanDataOe) o_oe_n++;
      if (WrReady) o_wrr_n++;
      if (RdValid) begin
        o_rdv_rel.push_back(cur.rel);
        o_rdv_dat.push_back(RdData);
      end
      if (Done) begin
        o_done = cur.rel;
        o_done_n++;
      end
    end
  end

  task automatic obs_clear();
    o_cs = -1; o_cs_n = 0; o_rd = -1; o_rd_n = 0;
    o_wr_n = 0; o_oe_n = 0; o_wrr_n = 0;
    o_done = -1; o_done_n = 0; prev_cs_low = 0;
    o_addr.delete(); o_dout.delete();
    o_rdv_rel.delete(); o_rdv_dat.delete();
  endtask

  function automatic rec_t base();
    rec_t r;
    r.rst = 0; r.chk = 1; r.rel = 0;
    r.cv = 0; r.cw = 1'($urandom); r.ci = 1'($urandom);
    r.ca = 10'($urandom); r.cl = 8'($urandom);
    r.wv = 1'($urandom); r.wd = 16'($urandom);
    r.li = 16'($urandom);
    r.cr = 1; r.busy = 0; r.wrr = 0; r.rdv = 0; r.done = 0;
    r.oe = 0; r.cs = 1; r.rd = 1; r.wr = 1;
    r.addr = m_addr; r.dout = m_dout; r.rdata = m_rdata;
    return r;
  endfunction

  function automatic rec_t busyb(input bit w, input int rel);
    rec_t r;
    r = base();
    r.cr = 0; r.busy = 1; r.oe = w;
    r.cv = 1'($urandom);
    r.rel = rel;
    return r;
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) sched.push_back(base());
  endtask

  task automatic add_reset();
    rec_t r;
    m_addr = '0; m_dout = '0; m_rdata = '0;
    r = base(); r.rst = 1; r.cr = 0;
    sched.push_back(r);
  endtask

  // Expand one command into its per-cycle expected behaviour
  task automatic add_cmd(input bit w, input logic [9:0] a,
                         input int len, input bit inc);
    rec_t r;
    int rel;
    int ns;
    r = base();
    r.cv = 1; r.cw = w; r.ca = a; r.cl = 8'(len); r.ci = inc;
    sched.push_back(r);
    m_addr = a;
    rel = 1;
    for (int k = 0; k < len; k++) begin
      ns = SETUP + (w ? stall_arr[k] : 0);
      for (int j = 0; j < ns; j++) begin
        r = busyb(w, rel); rel++;
        if (w && j >= SETUP - 1) begin
          r.wv = (j == ns - 1);
          if (j == ns - 1) begin
            r.wd = wd_arr[k];
            r.wrr = 1;
          end
        end
        sched.push_back(r);
      end
      if (w) m_dout = wd_arr[k];
      for (int j = 0; j < ACTIVE; j++) begin
        r = busyb(w, rel); rel++;
        r.cs = 0;
        if (w) r.wr = 0;
        else r.rd = 0;
        if (!w && j == ACTIVE - 1) r.li = rd_arr[k];
        sched.push_back(r);
      end
      if (!w) m_rdata = rd_arr[k];
      for (int j = 0; j < HOLD; j++) begin
        r = busyb(w, rel); rel++;
        if (!w && j == 0) r.rdv = 1;
        sched.push_back(r);
      end
      if (inc && k < len - 1) m_addr = m_addr + 10'd2;
    end
    r = busyb(w, rel);
    r.done = 1;
    sched.push_back(r);
  endtask

  task automatic fill_rand(input int maxstall);
    for (int i = 0; i < 256; i++) begin
      stall_arr[i] = (maxstall > 0) ? $urandom_range(0, maxstall) : 0;
      wd_arr[i] = 16'($urandom);
      rd_arr[i] = 16'($urandom);
    end
  endtask

  task automatic play();
    rec_t r;
    while (sched.size() > 0) begin
      r = sched.pop_front();
      @(posedge Clk); #1;
      Rst = r.rst; CmdValid = r.cv; CmdWrite = r.cw;
      CmdInc = r.ci; CmdAddr = r.ca; CmdLen = r.cl;
      WrValid = r.wv; WrData = r.wd; LanDataIn = r.li;
      cur = r;
    end
    @(posedge Clk); #1;
    cur.chk = 0; CmdValid = 0; Rst = 0;
  endtask

  initial begin
    rec_t r;
    int s0;
    cur.chk = 0;
    Rst = 1; CmdValid = 0; CmdWrite = 0; CmdInc = 0;
    CmdAddr = '0; CmdLen = '0; WrValid = 0; WrData = '0;
    LanDataIn = '0;
    m_addr = '0; m_dout = '0; m_rdata = '0;
    fill_rand(0);

    r = base(); r.rst = 1; r.chk = 0; sched.push_back(r);
    add_reset();
    add_idle(2);
    play();

    obs_clear();
    wd_arr[0] = 16'h0050;
    add_cmd(1, 10'h20A, 1, 0); add_idle(2); play();
    chk("t1_cs_first", o_cs, 6);
    chk("t1_cs_len", o_cs_n, 5);
    chk("t1_wr_len", o_wr_n, 5);
    chk("t1_rd_never", o_rd_n, 0);
    chk("t1_addr", o_addr[0], 32'h20A);
    chk("t1_data", o_dout[0], 32'h0050);
    chk("t1_done", o_done, 16);

    obs_clear();
    rd_arr[0] = 16'h0017;
    add_cmd(0, 10'h208, 1, 0); add_idle(2); play();
    chk("t2_rd_first", o_rd, 6);
    chk("t2_rd_len", o_rd_n, 5);
    chk("t2_rdv_rel", o_rdv_rel[0], 11);
    chk("t2_rdv_dat", o_rdv_dat[0], 32'h0017);
    chk("t2_oe", o_oe_n, 0);
    chk("t2_done", o_done, 16);

    obs_clear();
    wd_arr[0] = 16'hAABB; wd_arr[1] = 16'hCCDD; wd_arr[2] = 16'hEEFF;
    add_cmd(1, 10'h008, 3, 1); add_idle(1); play();
    chk("t3_addr0", o_addr[0], 32'h008);
    chk("t3_addr1", o_addr[1], 32'h00A);
    chk("t3_addr2", o_addr[2], 32'h00C);
    chk("t3_data2", o_dout[2], 32'hEEFF);
    chk("t3_wrready", o_wrr_n, 3);
    chk("t3_done", o_done, 46);

    obs_clear();
    for (int i = 0; i < 4; i++) rd_arr[i] = 16'(i + 1);
    add_cmd(0, 10'h230, 4, 0); add_idle(1); play();
    chk("t4_rdv_n", o_rdv_rel.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_addr", o_addr[i], 32'h230);
      chk("t4_rdv_rel", o_rdv_rel[i], 11 + 15 * i);
      chk("t4_rdv_dat", o_rdv_dat[i], i + 1);
    end

    obs_clear();
    wd_arr[0] = 16'h1234; wd_arr[1] = 16'h5678;
    stall_arr[1] = 7;
    add_cmd(1, 10'h100, 2, 1); add_idle(1); play();
    stall_arr[1] = 0;
    chk("t5_done", o_done, 38);
    chk("t5_data1", o_dout[1], 32'h5678);
    chk("t5_cs_len", o_cs_n, 10);

    obs_clear();
    add_cmd(1, 10'h044, 0, 1); add_idle(1); play();
    chk("t6_done", o_done, 1);
    chk("t6_cs", o_cs_n, 0);

    obs_clear();
    add_cmd(0, 10'h3FE, 2, 1); add_idle(1); play();
    chk("t7_addr0", o_addr[0], 32'h3FE);
    chk("t7_addr1", o_addr[1], 32'h000);

    obs_clear();
    s0 = sched.size();
    add_cmd(0, 10'h150, 3, 1);
    while (sched.size() > s0 + SETUP + 4) void'(sched.pop_back());
    sched[s0 + SETUP + 3].rst = 1;
    add_reset();
    add_idle(2);
    play();
    chk("t8_no_done", o_done_n, 0);
    chk("t8_cs_len", o_cs_n, 3);
    chk("t8_no_rdv", o_rdv_rel.size(), 0);

    fill_rand(3);
    for (int n = 0; n < 40; n++) begin
      add_cmd(1'($urandom), 10'($urandom), $urandom_range(0, 4),
              1'($urandom));
      add_idle($urandom_range(0, 2));
      fill_rand(3);
    end
    add_idle(1);
    play();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
